mul_alu_sequencer: RTL and testbench



---
 rtl/mul_alu_seq_pkg.sv | 77 +++++++
 rtl/mul_alu_seq_decode.sv | 74 +++++++
 rtl/mul_alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mul_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_alu_seq_pkg.sv
// mul_alu_seq_pkg
//   Shared definitions for the hardwired control-step sequencer of the
//   single-bus CPU datapath: control-step state enum, opcode constants,
//   IR field positions, the strobe bundle produced by the decoder and
//   opcode classification helpers.
package mul_alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } seq_state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  // IR field bit positions; ra/rb/rc are consumed by the register
  // select/encode logic next to the datapath, not by the sequencer.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // One bit per datapath control strobe.
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobe_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_MUL, OP_DIV: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // MUL/DIV produce a 64-bit result and take the extra HI/LO steps.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_alu_seq_decode.sv
// mul_alu_seq_decode
//   Combinational decode of the current control step (plus the latched
//   opcode) into the datapath strobe bundle and ALU operation code.
// Ports:
//   state    in   current control step
//   opcode   in   opcode latched at T3
//   mem_take in   T1 is being left this cycle (read data is captured)
//   strobes  out  datapath strobe bundle
//   alu_op   out  ALU operation code, non-zero only in T4
module mul_alu_seq_decode
  import mul_alu_seq_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  seq_state_t       state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_take,
  output strobe_t          strobes,
  output logic [OPC_W-1:0] alu_op
);

  always_comb begin
    strobes = '0;
    alu_op  = '0;
    case (state)
      S_T0: begin
        strobes.pc_out  = 1'b1;
        strobes.mar_in  = 1'b1;
        strobes.inc_pc  = 1'b1;
        strobes.zlow_in = 1'b1;
      end
      S_T1: begin
        // Read stays up for the whole wait; PC and MDR load only in the
        // cycle where memory hands over the data, since that cycle is the
        // one that leaves T1.
        strobes.zlow_out = 1'b1;
        strobes.read     = 1'b1;
        strobes.pc_in    = mem_take;
        strobes.mdr_in   = mem_take;
      end
      S_T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      S_T3: begin
        strobes.grb   = 1'b1;
        strobes.r_out = 1'b1;
        strobes.y_in  = 1'b1;
      end
      S_T4: begin
        strobes.grc      = 1'b1;
        strobes.r_out    = 1'b1;
        strobes.zlow_in  = 1'b1;
        strobes.zhigh_in = is_muldiv(opcode);
        alu_op           = opcode;
      end
      S_T5: begin
        strobes.zlow_out = 1'b1;
        if (is_muldiv(opcode)) begin
          strobes.lo_in = 1'b1;
        end else begin
          strobes.gra  = 1'b1;
          strobes.r_in = 1'b1;
        end
      end
      S_T6: begin
        strobes.zhigh_out = 1'b1;
        strobes.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_alu_sequencer.sv
// mul_alu_sequencer
//   Hardwired control-step sequencer for the single-bus CPU datapath.
//   Fetches through PC/MAR/MDR, loads IR, then runs the execute steps for
//   R-format ALU ops (T3..T5) and MUL/DIV (T3..T6, writing LO then HI).
// Ports:
//   Clock, Clear            clock; asynchronous active-high reset
//   Run                     keep executing instructions (sampled in IDLE/DONE)
//   MemReady                memory read data valid this cycle
//   IR                      instruction register contents
//   PCout..Rout             datapath bus-drive, load and select strobes
//   ALUop                   ALU operation code (T4 only)
//   Busy, Done, Fault       status: not idle, completion pulse, sticky error
//   Step                    only with SEQ_STEP_EN: advance enable for
//                           single-stepping the sequence
// Build option:
//   SEQ_STEP_EN             adds the Step input
module mul_alu_sequencer
  import mul_alu_seq_pkg::*;
#(
  parameter int IR_W         = 32,
  parameter int OPC_W        = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Run,
  input  logic             MemReady,
  input  logic [IR_W-1:0]  IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             ZHighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowIn,
  output logic             ZHighIn,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [OPC_W-1:0] ALUop,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             Busy,
  output logic             Done,
  output logic             Fault
`ifdef SEQ_STEP_EN
  ,
  input  logic             Step
`endif
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             fault_q, fault_next;
  logic [OPC_W-1:0] opcode_q, opcode_next;
  logic [OPC_W-1:0] ir_opcode;
  logic             advance;
  logic             mem_take;
  strobe_t          strobes;

  // The register fields of IR belong to the register select logic.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[IR_W-OPC_W-1:0];

  assign ir_opcode = IR[IR_W-1 -: OPC_W];

`ifdef SEQ_STEP_EN
  logic done_held;

  assign advance = Step;

  // Remembers that DONE has already been shown once so a held DONE
  // produces a single Done pulse.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      done_held <= 1'b0;
    end else begin
      done_held <= (state == S_DONE) && !advance;
    end
  end

  assign Done = (state == S_DONE) && !done_held;
`else
  assign advance = 1'b1;
  assign Done    = (state == S_DONE);
`endif

  assign mem_take = MemReady && advance;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      opcode_q <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      fault_q  <= fault_next;
      opcode_q <= opcode_next;
    end
  end

  // Next-step logic. Held cycles (advance low) change nothing, so they
  // also do not count toward the memory timeout.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    fault_next    = fault_q;
    opcode_next   = opcode_q;
    if (state == S_IDLE) begin
      if (Run && !fault_q) begin
        state_next = S_T0;
      end
    end else if (advance) begin
      case (state)
        S_T0: begin
          state_next    = S_T1;
          wait_cnt_next = '0;
        end
        S_T1: begin
          if (MemReady) begin
            state_next = S_T2;
          end else if (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1)) begin
            fault_next = 1'b1;
            state_next = S_IDLE;
          end else begin
            wait_cnt_next = wait_cnt + 1'b1;
          end
        end
        S_T2: state_next = S_T3;
        S_T3: begin
          // Latch the opcode so T4..T6 do not depend on IR staying put.
          opcode_next = ir_opcode;
          if (is_legal_op(ir_opcode)) begin
            state_next = S_T4;
          end else begin
            fault_next = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_T4:    state_next = S_T5;
        S_T5:    state_next = is_muldiv(opcode_q) ? S_T6 : S_DONE;
        S_T6:    state_next = S_DONE;
        S_DONE:  state_next = Run ? S_T0 : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  mul_alu_seq_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state    (state),
    .opcode   (opcode_q),
    .mem_take (mem_take),
    .strobes  (strobes),
    .alu_op   (ALUop)
  );

  assign PCout    = strobes.pc_out;
  assign Zlowout  = strobes.zlow_out;
  assign ZHighout = strobes.zhigh_out;
  assign MDRout   = strobes.mdr_out;
  assign MARin    = strobes.mar_in;
  assign PCin     = strobes.pc_in;
  assign MDRin    = strobes.mdr_in;
  assign IRin     = strobes.ir_in;
  assign Yin      = strobes.y_in;
  assign ZLowIn   = strobes.zlow_in;
  assign ZHighIn  = strobes.zhigh_in;
  assign HIin     = strobes.hi_in;
  assign LOin     = strobes.lo_in;
  assign IncPC    = strobes.inc_pc;
  assign Read     = strobes.read;
  assign Gra      = strobes.gra;
  assign Grb      = strobes.grb;
  assign Grc      = strobes.grc;
  assign Rin      = strobes.r_in;
  assign Rout     = strobes.r_out;
  assign Busy     = (state != S_IDLE);
  assign Fault    = fault_q;

endmodule

// File: tb/tb_mul_alu_sequencer.sv
// tb_mul_alu_sequencer
//   Scoreboard bench: each issued instruction pushes its expected per-cycle
//   output trace (built from the instruction's opcode and memory stall
//   count) into a queue; a monitor pops one entry per busy cycle.
module tb_mul_alu_sequencer;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] SHR = 5'b00111, SHL = 5'b01000, MUL = 5'b01110, DIV = 5'b01111;

  localparam logic [19:0] M_PCOUT = 20'h00001, M_ZLOWOUT = 20'h00002, M_ZHIGHOUT = 20'h00004;
  localparam logic [19:0] M_MDROUT = 20'h00008, M_MARIN = 20'h00010, M_PCIN = 20'h00020;
  localparam logic [19:0] M_MDRIN = 20'h00040, M_IRIN = 20'h00080, M_YIN = 20'h00100;
  localparam logic [19:0] M_ZLOWIN = 20'h00200, M_ZHIGHIN = 20'h00400, M_HIIN = 20'h00800;
  localparam logic [19:0] M_LOIN = 20'h01000, M_INCPC = 20'h02000, M_READ = 20'h04000;
  localparam logic [19:0] M_GRA = 20'h08000, M_GRB = 20'h10000, M_GRC = 20'h20000;
  localparam logic [19:0] M_RIN = 20'h40000, M_ROUT = 20'h80000;

  localparam logic [27:0] IDLE_FAULTED = 28'h2000000;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Run = 1'b0;
  logic        MemReady = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin;
  logic ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0] ALUop;
  logic Busy, Done, Fault;
`ifdef SEQ_STEP_EN
  logic Step = 1'b1;
`endif

  mul_alu_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .ALUop(ALUop), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .Busy(Busy), .Done(Done), .Fault(Fault)
`ifdef SEQ_STEP_EN
    , .Step(Step)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        mr;
    logic [27:0] v;
  } step_t;

  step_t       trace_q[$];
  logic [27:0] exp_q[$];
  logic        trace_faults;
  int          checks = 0;
  int          fails = 0;

  function automatic logic [27:0] observed();
    return {Busy, Done, Fault, ALUop,
            Rout, Rin, Grc, Grb, Gra, Read, IncPC, LOin, HIin, ZHighIn,
            ZLowIn, Yin, IRin, MDRin, PCin, MARin, MDRout, ZHighout, Zlowout, PCout};
  endfunction

  function automatic logic [27:0] enc(input logic [19:0] s, input logic [4:0] alu, input logic dn);
    return {1'b1, dn, 1'b0, alu, s};
  endfunction

  // Reference model: the expected busy-cycle trace of one instruction.
  task automatic buildTrace(input logic [31:0] ir, input int stalls);
    logic [4:0] op;
    logic       legal, md;
    int         ns;
    op    = ir[31:27];
    legal = op inside {ADD, SUB, AND_, OR_, SHR, SHL, MUL, DIV};
    md    = (op == MUL) || (op == DIV);
    trace_q.delete();
    trace_faults = 1'b0;
    trace_q.push_back('{1'b0, enc(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'd0, 1'b0)});
    ns = (stalls > 15) ? 15 : stalls;
    for (int k = 0; k < ns; k++)
      trace_q.push_back('{1'b0, enc(M_ZLOWOUT | M_READ, 5'd0, 1'b0)});
    if (stalls >= 15) begin
      trace_faults = 1'b1;
      return;
    end
    trace_q.push_back('{1'b1, enc(M_ZLOWOUT | M_READ | M_PCIN | M_MDRIN, 5'd0, 1'b0)});
    trace_q.push_back('{1'b0, enc(M_MDROUT | M_IRIN, 5'd0, 1'b0)});
    trace_q.push_back('{1'b0, enc(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0)});
    if (!legal) begin
      trace_faults = 1'b1;
      return;
    end
    trace_q.push_back('{1'b0, enc(M_GRC | M_ROUT | M_ZLOWIN | (md ? M_ZHIGHIN : 20'h0), op, 1'b0)});
    if (md) begin
      trace_q.push_back('{1'b0, enc(M_ZLOWOUT | M_LOIN, 5'd0, 1'b0)});
      trace_q.push_back('{1'b0, enc(M_ZHIGHOUT | M_HIIN, 5'd0, 1'b0)});
    end else begin
      trace_q.push_back('{1'b0, enc(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0)});
    end
    trace_q.push_back('{1'b0, enc(20'h0, 5'd0, 1'b1)});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issues one instruction; cut > 0 stops driving after that many trace cycles.
  task automatic applyStimulus(input logic [31:0] ir, input int stalls, input bit chain,
                               input bit from_idle, input int cut, output bit faulted);
    int n;
    buildTrace(ir, stalls);
    faulted = trace_faults;
    n = (cut > 0 && cut < trace_q.size()) ? cut : trace_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(trace_q[i].v);
    IR = ir;
    if (from_idle) begin
      Run = 1'b1;
      MemReady = 1'b0;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      MemReady = trace_q[i].mr;
      Run = chain;
      tick();
    end
    MemReady = 1'b0;
  endtask

  task automatic doClear(input string name);
    Clear = 1'b1;
    #1;
    checkOutput(name, observed(), 28'h0);
    tick();
    Clear = 1'b0;
    Run = 1'b0;
    tick();
    checkOutput("idle_after_clear", observed(), 28'h0);
  endtask

  task automatic checkFaultBlocked(input string name);
    Run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput(name, observed(), IDLE_FAULTED);
      tick();
    end
    doClear("clear_fault");
  endtask

  always @(negedge Clock) begin
    if (Busy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL busy_unexpected actual=%h required=idle", observed());
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if (observed() !== e) begin
          fails++;
          $display("[TB] FAIL cycle_outputs actual=%h required=%h", observed(), e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] legal_ops[8];
    logic [4:0] illegal_ops[5];
    logic [4:0] op;
    bit         f, chain, from_idle;
    int         r, st;
    legal_ops   = '{ADD, SUB, AND_, OR_, SHR, SHL, MUL, DIV};
    illegal_ops = '{5'b00000, 5'b00001, 5'b01001, 5'b10000, 5'b11111};

    Clear = 1'b1;
    tick();
    checkOutput("reset_state", observed(), 28'h0);
    tick();
    Clear = 1'b0;
    tick();
    checkOutput("idle_after_reset", observed(), 28'h0);

    $display("[TB] MUL, no stall");
    applyStimulus(32'h70120000, 0, 1'b0, 1'b1, 0, f);
    checkOutput("idle_after_mul", observed(), 28'h0);

    $display("[TB] ADD, no stall");
    applyStimulus(32'h1A920000, 0, 1'b0, 1'b1, 0, f);
    checkOutput("idle_after_add", observed(), 28'h0);

    $display("[TB] ADD, 3 stall cycles; SUB, 14 stall cycles");
    applyStimulus(32'h1A920000, 3, 1'b0, 1'b1, 0, f);
    applyStimulus(32'h22920000, 14, 1'b0, 1'b1, 0, f);

    $display("[TB] memory timeout");
    applyStimulus(32'h1A920000, 40, 1'b1, 1'b1, 0, f);
    checkFaultBlocked("timeout_blocked");

    $display("[TB] illegal opcode");
    applyStimulus(32'hF8000000, 0, 1'b1, 1'b1, 0, f);
    checkFaultBlocked("illegal_blocked");

    $display("[TB] Clear during T4");
    applyStimulus(32'h70120000, 0, 1'b0, 1'b1, 4, f);
    doClear("clear_mid_t4");

    $display("[TB] back-to-back DIV then OR");
    applyStimulus(32'h78120000, 1, 1'b1, 1'b1, 0, f);
    applyStimulus(32'h32920000, 0, 1'b0, 1'b0, 0, f);
    checkOutput("idle_after_chain", observed(), 28'h0);

    $display("[TB] randomized instruction stream");
    from_idle = 1'b1;
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 11);
      op = (r < 10) ? legal_ops[$urandom_range(0, 7)] : illegal_ops[$urandom_range(0, 4)];
      r  = $urandom_range(0, 9);
      st = (r < 7) ? (r % 4) : ((r == 7) ? 14 : ((r == 8) ? 15 : 20));
      chain = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus({op, 27'($urandom())}, st, chain, from_idle, 0, f);
      if (f) begin
        checkFaultBlocked("random_fault");
        from_idle = 1'b1;
      end else begin
        from_idle = !chain;
      end
    end

    tick();
    tick();
    checkOutput("final_idle", observed(), 28'h0);
    checkOutput("scoreboard_drained", 28'(exp_q.size()), 28'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
